// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port sync RAM between instruction fetch and load/store,
// data-first with a fetch starvation bound; sub-word stores become read-modify-write.
module riscv_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic              ram_wren_o,
    input  logic [31:0]       ram_q_i
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, RMW_RD, RMW_MRG, WRITE} state_e;
    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                wren_q, wren_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic                d_done_q, d_done_d;
    logic                idle, starve;
    logic [31:0]         mask;
    logic                unused_bits;
    assign unused_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0], d_addr_i[31:ADDR_W+2], d_addr_i[1:0]};
    assign idle     = state_q == IDLE;
    assign starve   = if_req_i && cnt_q == 4'(STARVE_MAX);
    assign d_gnt_o  = idle && d_req_i && !starve;
    assign if_gnt_o = idle && if_req_i && !d_gnt_o;
    assign mask     = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    assign if_rdata_o  = ram_q_i;
    assign d_rdata_o   = ram_q_i;
    assign if_rvalid_o = if_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign d_done_o    = d_done_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign ram_wren_o  = wren_q;
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        wren_d      = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        d_done_d    = 1'b0;
        cnt_d       = (!if_req_i || if_gnt_o) ? 4'd0 : d_gnt_o ? cnt_q + 4'd1 : cnt_q;
        case (state_q)
            IDLE: begin
                if (if_gnt_o) begin
                    state_d = FETCH;
                    addr_d  = if_addr_i[ADDR_W+1:2];
                end else if (d_gnt_o) begin
                    addr_d  = d_addr_i[ADDR_W+1:2];
                    wdata_d = d_wdata_i;
                    be_d    = d_be_i;
                    // empty byte-enable stores complete without touching the RAM
                    if (!d_we_i) state_d = LOAD;
                    else if (d_be_i == 4'hF) begin
                        state_d = WRITE;
                        wren_d  = 1'b1;
                    end else if (d_be_i == 4'h0) d_done_d = 1'b1;
                    else state_d = RMW_RD;
                end
            end
            FETCH: begin
                state_d     = IDLE;
                if_rvalid_d = 1'b1;
            end
            LOAD: begin
                state_d    = IDLE;
                d_rvalid_d = 1'b1;
            end
            RMW_RD: state_d = RMW_MRG;
            RMW_MRG: begin
                wdata_d = (ram_q_i & ~mask) | (wdata_q & mask);
                wren_d  = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                state_d  = IDLE;
                d_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            wren_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            wren_q      <= wren_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            d_done_q    <= d_done_d;
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed checks of the RAM arbiter against a behavioural sync RAM.
module tb_riscv_mem_arbiter;
    localparam int AW = 10;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0]   if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]    d_be = '0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, d_done, ram_wren;
    logic [31:0]   if_rdata, d_rdata, ram_wdata, ram_q;
    logic [AW-1:0] ram_addr;
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          loaded = 1'b0;
    int            n_run = 0, n_fail = 0;

    riscv_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
        .d_rdata_o(d_rdata), .d_done_o(d_done),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wren_o(ram_wren),
        .ram_q_i(ram_q)
    );

    always #5 clk = ~clk;

    // RAM model: word i preloads to 0xC0DE0000+i, except word 4
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hC0DE0000 + i;
            mem[4] <= 32'h11223344;
            loaded <= 1'b1;
        end else begin
            if (ram_wren) mem[ram_addr] <= ram_wdata;
            ram_q <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // starts at posedge+1; cycle numbers count from the grant cycle
    task automatic txn(input string tag, input logic is_d, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [AW-1:0] exp_ra,
                       input int exp_lat, input logic chk_data, input logic [31:0] exp_data,
                       input int exp_wren);
        logic got;
        int lat, wr;
        logic [31:0] dat;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = is_d ? d_gnt : if_gnt;
            if (got) chk({tag, " gnt_excl"}, {31'b0, if_gnt & d_gnt}, 32'd0);
            else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, " granted"}, {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0; if_req = 1'b0;
        got = 1'b0; lat = 0; wr = 0; dat = '0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (i == 1) chk({tag, " ram_addr"}, 32'(ram_addr), 32'(exp_ra));
            wr += int'(ram_wren);
            got = !is_d ? if_rvalid : (we ? d_done : d_rvalid);
            if (got) begin
                lat = i;
                dat = is_d ? d_rdata : if_rdata;
            end
            @(posedge clk); #1;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " wren_cycles"}, 32'(wr), 32'(exp_wren));
        if (chk_data) chk({tag, " rdata"}, dat, exp_data);
    endtask

    initial begin : main
        logic [9:0] seq;
        int k, both, wr, dn;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ram_addr", 32'(ram_addr), 32'd0);
        chk("rst ram_wdata", ram_wdata, 32'd0);
        chk("rst ram_wren", {31'b0, ram_wren}, 32'd0);
        chk("rst if_rvalid", {31'b0, if_rvalid}, 32'd0);
        chk("rst d_rvalid", {31'b0, d_rvalid}, 32'd0);
        chk("rst d_done", {31'b0, d_done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn("fetch08", 1'b0, 1'b0, 4'h0, 32'h08, 32'h0, 10'd2, 2, 1'b1, 32'hC0DE0002, 0);
        txn("sb_lane2", 1'b1, 1'b1, 4'b0100, 32'h10, 32'h00AA0000, 10'd4, 4, 1'b0, 32'h0, 1);
        chk("sb_lane2 mem", mem[4], 32'h11AA3344);
        txn("lw_after_sb", 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 10'd4, 2, 1'b1, 32'h11AA3344, 0);
        txn("sw_full", 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 10'd4, 2, 1'b0, 32'h0, 1);
        txn("lw_after_sw", 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 10'd4, 2, 1'b1, 32'hDEADBEEF, 0);
        txn("sh_upper", 1'b1, 1'b1, 4'b1100, 32'h14, 32'h55660000, 10'd5, 4, 1'b0, 32'h0, 1);
        chk("sh_upper mem", mem[5], 32'h55660005);
        txn("st_be0", 1'b1, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, 10'd12, 1, 1'b0, 32'h0, 0);
        chk("st_be0 mem", mem[12], 32'hC0DE000C);
        txn("lw_wrap", 1'b1, 1'b0, 4'h0, 32'h1004, 32'h0, 10'd1, 2, 1'b1, 32'hC0DE0001, 0);

        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; if_req = 1'b1; if_addr = 32'h24;
        seq = '0; k = 0; both = 0;
        for (int i = 0; i < 60 && k < 10; i++) begin
            @(negedge clk);
            if (if_gnt && d_gnt) both++;
            if (if_gnt || d_gnt) begin
                seq[k] = if_gnt;
                k++;
            end
            @(posedge clk); #1;
        end
        d_req = 1'b0; if_req = 1'b0;
        chk("starve grants", 32'(k), 32'd10);
        chk("starve order", 32'(seq), 32'(10'b1000010000));
        chk("starve both_gnt", 32'(both), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0001; d_addr = 32'h18; d_wdata = 32'h000000FF;
        @(negedge clk);
        chk("rmw_rst gnt", {31'b0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rmw_rst wren", {31'b0, ram_wren}, 32'd0);
        wr = 0; dn = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr += int'(ram_wren);
            dn += int'(d_done);
            if (i == 2) rst_n = 1'b1;
            @(posedge clk); #1;
        end
        chk("rmw_rst wren_cycles", 32'(wr), 32'd0);
        chk("rmw_rst done", 32'(dn), 32'd0);
        chk("rmw_rst mem", mem[6], 32'hC0DE0006);
        txn("fetch_after_rst", 1'b0, 1'b0, 4'h0, 32'h18, 32'h0, 10'd6, 2, 1'b1, 32'hC0DE0006, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
